// File: rtl/cnt_credit_pkg.sv
// Shared types and helpers for the consumer-side credit gate.
//   state_e         : grant FSM states (idle / offering a grant / settling avail).
//   grant_len_width : width of the grant length field, enough to hold 1..2^burst_log2.
package cnt_credit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOffer,
    StSettle
  } state_e;

  function automatic int unsigned grant_len_width(input int unsigned burst_log2);
    return burst_log2 + 1;
  endfunction

endpackage

// File: rtl/cnt_credit_gate.sv
// Consumer-side credit gate. Compares the synchronized producer count against the count of
// items already granted and hands out burst grants over a valid/ready handshake.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   remote_cnt   : producer count, already synchronized and gray-decoded
//   enable       : permits new grants
//   flush        : permits a partial grant when fewer than a full burst is available
//   grant_valid  : grant offered
//   grant_ready  : grant accepted
//   grant_len    : items in the offered grant (1..BURST)
//   avail        : registered remote_cnt - local_cnt (modular)
//   local_cnt    : total items granted (modular)
//   ovf_err      : sticky overflow flag (avail > DEPTH)
//   stall_err    : sticky stall watchdog flag
//
// Optional feature: define CNT_CREDIT_GATE_STALL_WD_EN to build the stall watchdog; otherwise
// stall_err is tied to 0.
module cnt_credit_gate
  import cnt_credit_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned BURST_LOG2 = 4,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned WD_LOG2    = 12
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [CNT_WIDTH-1:0]                     remote_cnt,
  input  logic                                     enable,
  input  logic                                     flush,
  output logic                                     grant_valid,
  input  logic                                     grant_ready,
  output logic [grant_len_width(BURST_LOG2)-1:0]   grant_len,
  output logic [CNT_WIDTH-1:0]                     avail,
  output logic [CNT_WIDTH-1:0]                     local_cnt,
  output logic                                     ovf_err,
  output logic                                     stall_err
);

  localparam int unsigned Burst = 2 ** BURST_LOG2;
  localparam int unsigned LenW  = grant_len_width(BURST_LOG2);
  localparam logic [CNT_WIDTH-1:0] BurstCnt = CNT_WIDTH'(Burst);
  localparam logic [CNT_WIDTH-1:0] DepthCnt = CNT_WIDTH'(DEPTH);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  avail_q, avail_d;
  logic [CNT_WIDTH-1:0]  local_cnt_q, local_cnt_d;
  logic [LenW-1:0]       grant_len_q, grant_len_d;
  logic                  ovf_err_q, ovf_err_d;
  logic                  handshake;
  logic                  ovf_now;

  assign handshake = (state_q == StOffer) && grant_ready;
  // Overflow seen this cycle also blocks a grant, so a bogus avail is never granted from.
  assign ovf_now   = avail_q > DepthCnt;

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      avail_q     <= '0;
      local_cnt_q <= '0;
      grant_len_q <= '0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      avail_q     <= avail_d;
      local_cnt_q <= local_cnt_d;
      grant_len_q <= grant_len_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  // Next-state and grant length latch.
  always_comb begin
    state_d     = state_q;
    grant_len_d = grant_len_q;
    unique case (state_q)
      StIdle: begin
        if (ovf_err_q || ovf_now) begin
          state_d = StIdle;
        end else if (enable && (avail_q >= BurstCnt)) begin
          grant_len_d = LenW'(Burst);
          state_d     = StOffer;
        end else if (enable && flush && (avail_q != '0)) begin
          // avail_q < Burst here, so the low bits hold the whole remainder.
          grant_len_d = avail_q[LenW-1:0];
          state_d     = StOffer;
        end
      end
      StOffer: begin
        if (grant_ready) state_d = StSettle;
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Credit arithmetic; modular subtraction makes counter wrap transparent.
  always_comb begin
    avail_d     = remote_cnt - local_cnt_q;
    local_cnt_d = local_cnt_q;
    if (handshake) local_cnt_d = local_cnt_q + CNT_WIDTH'(grant_len_q);
    ovf_err_d   = ovf_err_q | ovf_now;
  end

  // Outputs.
  always_comb begin
    grant_valid = (state_q == StOffer);
    grant_len   = grant_len_q;
    avail       = avail_q;
    local_cnt   = local_cnt_q;
    ovf_err     = ovf_err_q;
  end

`ifdef CNT_CREDIT_GATE_STALL_WD_EN
  logic [WD_LOG2-1:0] wd_cnt_q, wd_cnt_d;
  logic               stall_err_q, stall_err_d;

  always_comb begin
    wd_cnt_d = '0;
    if ((state_q == StOffer) && !grant_ready) begin
      wd_cnt_d = (&wd_cnt_q) ? wd_cnt_q : wd_cnt_q + 1'b1;
    end
    stall_err_d = stall_err_q | (&wd_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q    <= '0;
      stall_err_q <= 1'b0;
    end else begin
      wd_cnt_q    <= wd_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign stall_err = stall_err_q;
`else
  logic unused_wd;
  assign unused_wd = ^WD_LOG2;
  assign stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_credit_gate.sv
// Self-checking bench for cnt_credit_gate: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level credit model.
module tb_cnt_credit_gate;

  localparam int unsigned Depth = 1024;
  localparam int unsigned Burst = 16;

  logic        clk;
  logic        rst;
  logic [15:0] remote_cnt;
  logic        enable;
  logic        flush;
  logic        grant_valid;
  logic        grant_ready;
  logic [4:0]  grant_len;
  logic [15:0] avail;
  logic [15:0] local_cnt;
  logic        ovf_err;
  logic        stall_err;

  cnt_credit_gate dut (
    .clk         (clk),
    .rst         (rst),
    .remote_cnt  (remote_cnt),
    .enable      (enable),
    .flush       (flush),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_len   (grant_len),
    .avail       (avail),
    .local_cnt   (local_cnt),
    .ovf_err     (ovf_err),
    .stall_err   (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cycle    = 0;

  // Reference model: credits granted, credits visible, pending offer, cooldown after a grant.
  logic [15:0] m_local;
  logic [15:0] m_avail;
  logic        m_offer;
  logic [4:0]  m_len;
  int unsigned m_cool;
  logic        m_ovf;
  logic        m_stall;
  int unsigned m_wait;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_local = '0;
    m_avail = '0;
    m_offer = 1'b0;
    m_len   = '0;
    m_cool  = 0;
    m_ovf   = 1'b0;
    m_stall = 1'b0;
    m_wait  = 0;
  endtask

  // Advance the model by one clock using the inputs that were stable before the edge.
  task automatic model_edge();
    logic [15:0] next_avail;
    next_avail = remote_cnt - m_local;
`ifdef CNT_CREDIT_GATE_STALL_WD_EN
    // Flag rises once an offer has waited 2^12-1 cycles unaccepted.
    if (m_wait >= 4095) m_stall = 1'b1;
    if (m_offer && !grant_ready) m_wait++;
    else m_wait = 0;
`endif
    if (m_offer && grant_ready) begin
      m_local = m_local + 16'(m_len);
      m_offer = 1'b0;
      m_cool  = 1;
    end else if (!m_offer) begin
      if (m_cool != 0) begin
        m_cool = m_cool - 1;
      end else if (!m_ovf && (m_avail <= Depth) && enable) begin
        if (m_avail >= Burst) begin
          m_offer = 1'b1;
          m_len   = 5'(Burst);
        end else if (flush && (m_avail != 0)) begin
          m_offer = 1'b1;
          m_len   = m_avail[4:0];
        end
      end
    end
    if (m_avail > Depth) m_ovf = 1'b1;
    m_avail = next_avail;
  endtask

  task automatic compare_all();
    check_eq("valid", {31'b0, grant_valid}, {31'b0, m_offer});
    if (m_offer) check_eq("len", {27'b0, grant_len}, {27'b0, m_len});
    check_eq("avail", {16'b0, avail}, {16'b0, m_avail});
    check_eq("local", {16'b0, local_cnt}, {16'b0, m_local});
    check_eq("ovf", {31'b0, ovf_err}, {31'b0, m_ovf});
    check_eq("stall", {31'b0, stall_err}, {31'b0, m_stall});
  endtask

  task automatic step();
    @(posedge clk);
    cycle++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    remote_cnt  = '0;
    enable      = 1'b0;
    flush       = 1'b0;
    grant_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned rises;
    int unsigned first_rise;
    int unsigned spacing;
    int unsigned budget;
    int unsigned valid_cycles;
    logic        prev_valid;

    // 1: two full bursts, 3-cycle spacing.
    do_reset();
    remote_cnt  = 16'h0020;
    enable      = 1'b1;
    grant_ready = 1'b1;
    rises = 0; first_rise = 0; spacing = 0; prev_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (grant_valid && !prev_valid) begin
        if (rises == 0) first_rise = cycle;
        else spacing = cycle - first_rise;
        rises++;
      end
      prev_valid = grant_valid;
    end
    check_eq("t1_rises", rises, 2);
    check_eq("t1_spacing", spacing, 3);
    check_eq("t1_local", {16'b0, local_cnt}, 32'h20);
    check_eq("t1_avail", {16'b0, avail}, 32'h0);

    // 2: partial grant only with flush.
    do_reset();
    remote_cnt = 16'h0007;
    enable     = 1'b1;
    grant_ready = 1'b1;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (grant_valid) rises++;
    end
    check_eq("t2_no_grant", rises, 0);
    flush = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check_eq("t2_local", {16'b0, local_cnt}, 32'h7);

    // 3: counter wrap at the top of the range.
    do_reset();
    enable      = 1'b1;
    grant_ready = 1'b1;
    budget = 0;
    while (m_local != 16'hFFF0 && budget < 14000) begin
      remote_cnt = (m_local >= 16'hFFE0) ? 16'hFFF0 : m_local + 16'd16;
      step();
      budget++;
    end
    check_eq("t3_preload_fff0", {16'b0, local_cnt}, 32'hFFF0);
    remote_cnt = 16'hFFF8;
    flush      = 1'b1;
    budget = 0;
    while (m_local != 16'hFFF8 && budget < 20) begin
      step();
      budget++;
    end
    check_eq("t3_preload_fff8", {16'b0, local_cnt}, 32'hFFF8);
    flush      = 1'b0;
    remote_cnt = 16'h0008;
    step();
    check_eq("t3_avail_wrap", {16'b0, avail}, 32'h0010);
    budget = 0;
    while (m_local != 16'h0008 && budget < 20) begin
      step();
      budget++;
    end
    check_eq("t3_local_wrap", {16'b0, local_cnt}, 32'h0008);
    for (int i = 0; i < 3; i++) step();

    // 4: producer overrun sets sticky overflow and blocks grants.
    remote_cnt = m_local + 16'd1025;
    step();
    check_eq("t4_avail", {16'b0, avail}, 32'd1025);
    check_eq("t4_ovf_lag", {31'b0, ovf_err}, 32'd0);
    step();
    check_eq("t4_ovf", {31'b0, ovf_err}, 32'd1);
    flush = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      remote_cnt  = m_local + 16'($urandom_range(0, 64));
      grant_ready = 1'($urandom_range(0, 1));
      step();
      if (grant_valid) valid_cycles++;
    end
    check_eq("t4_blocked", valid_cycles, 0);
    check_eq("t4_ovf_sticky", {31'b0, ovf_err}, 32'd1);

    // 5: offer held unaccepted; grant stays stable, watchdog behaviour per build.
    do_reset();
    remote_cnt = 16'h0010;
    enable     = 1'b1;
    for (int i = 0; i < 4110; i++) step();
    check_eq("t5_valid_held", {31'b0, grant_valid}, 32'd1);
    check_eq("t5_len_held", {27'b0, grant_len}, 32'd16);
`ifdef CNT_CREDIT_GATE_STALL_WD_EN
    check_eq("t5_stall", {31'b0, stall_err}, 32'd1);
`else
    check_eq("t5_stall", {31'b0, stall_err}, 32'd0);
`endif
    grant_ready = 1'b1;
    step();
    check_eq("t5_local", {16'b0, local_cnt}, 32'h10);

    // 6: asynchronous reset while offering.
    do_reset();
    remote_cnt  = 16'h0020;
    enable      = 1'b1;
    grant_ready = 1'b1;
    budget = 0;
    while (m_local != 16'h0010 && budget < 20) begin
      step();
      budget++;
    end
    grant_ready = 1'b0;
    budget = 0;
    while (!m_offer && budget < 20) begin
      step();
      budget++;
    end
    check_eq("t6_offer", {31'b0, grant_valid}, 32'd1);
    check_eq("t6_local_pre", {16'b0, local_cnt}, 32'h10);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_valid_rst", {31'b0, grant_valid}, 32'd0);
    check_eq("t6_avail_rst", {16'b0, avail}, 32'd0);
    check_eq("t6_local_rst", {16'b0, local_cnt}, 32'd0);
    check_eq("t6_ovf_rst", {31'b0, ovf_err}, 32'd0);
    check_eq("t6_stall_rst", {31'b0, stall_err}, 32'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with a bounded-lead producer.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [15:0] lead;
        lead = remote_cnt - m_local;
        if (lead < 16'd900) remote_cnt = remote_cnt + 16'($urandom_range(0, 6));
      end
      enable      = ($urandom_range(0, 7) != 0);
      flush       = ($urandom_range(0, 3) == 0);
      grant_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
